// File: rtl/decode_stage_if.sv
// Fetch/decode/execute handshake and control-bundle signals for decode_stage.
// slave: decode stage view (accepts from fetch, produces the bundle).
// master: surrounding pipeline view (fetch + execute).
interface decode_stage_if #(
    parameter int ADDRESS_BITS  = 32,
    parameter int ALU_CTRL_BITS = 6
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ADDRESS_BITS-1:0]  in_PC;
    logic [31:0]              instruction;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDRESS_BITS-1:0]  out_PC;
    logic [4:0]               read_sel1;
    logic [4:0]               read_sel2;
    logic [4:0]               rd;
    logic [2:0]               funct3;
    logic [6:0]               funct7;
    logic [31:0]              imm32;
    logic                     wEn;
    logic                     mem_wEn;
    logic                     branch_op;
    logic                     op_B_sel;
    logic                     wb_sel;
    logic                     load_extend_sign;
    logic [1:0]               op_A_sel;
    logic [ALU_CTRL_BITS-1:0] ALU_Control;
    logic [1:0]               MemSize;
    logic                     illegal;

    modport slave (
        input  in_valid, in_PC, instruction, flush, out_ready,
        output in_ready, out_valid, out_PC, read_sel1, read_sel2, rd,
               funct3, funct7, imm32, wEn, mem_wEn, branch_op, op_B_sel,
               wb_sel, load_extend_sign, op_A_sel, ALU_Control, MemSize, illegal
    );

    modport master (
        output in_valid, in_PC, instruction, flush, out_ready,
        input  in_ready, out_valid, out_PC, read_sel1, read_sel2, rd,
               funct3, funct7, imm32, wEn, mem_wEn, branch_op, op_B_sel,
               wb_sel, load_extend_sign, op_A_sel, ALU_Control, MemSize, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a one-entry registered
// control bundle with valid/ready flow control, load-use bubble and flush.
// Optional feature macro: DECODE_RV32M_EN (RV32M multiply/divide decode).
`ifndef ADD
`define ADD     6'h00
`define SUB     6'h01
`define SLL     6'h02
`define SLT     6'h03
`define SLTU    6'h04
`define XOR     6'h05
`define SRL     6'h06
`define SRA     6'h07
`define OR      6'h08
`define AND     6'h09
`define BEQ     6'h0A
`define BNE     6'h0B
`define BLT     6'h0C
`define BGE     6'h0D
`define BLTU    6'h0E
`define BGEU    6'h0F
`define JAL     6'h10
`define JALR    6'h11
`define MUL     6'h18
`define MULH    6'h19
`define MULHSU  6'h1A
`define MULHU   6'h1B
`define DIV     6'h1C
`define DIVU    6'h1D
`define REM     6'h1E
`define REMU    6'h1F
`define DEFAULT 6'h3F
`endif
`ifndef SIZE_BYTE
`define SIZE_BYTE  2'd0
`define SIZE_HWORD 2'd1
`define SIZE_WORD  2'd2
`endif

module decode_stage #(
    parameter int ADDRESS_BITS  = 32,
    parameter int ALU_CTRL_BITS = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    decode_stage_if.slave      bus
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic [4:0]               read_sel1;
        logic [4:0]               read_sel2;
        logic [4:0]               rd;
        logic [2:0]               funct3;
        logic [6:0]               funct7;
        logic [31:0]              imm32;
        logic                     wEn;
        logic                     mem_wEn;
        logic                     branch_op;
        logic                     op_B_sel;
        logic                     wb_sel;
        logic                     load_extend_sign;
        logic [1:0]               op_A_sel;
        logic [ALU_CTRL_BITS-1:0] ALU_Control;
        logic [1:0]               MemSize;
        logic                     illegal;
    } bundle_t;

    function automatic logic [ALU_CTRL_BITS-1:0] alu(input logic [5:0] code);
        return ALU_CTRL_BITS'(code);
    endfunction

    logic [31:0]             ins;
    opcode_e                 opcode;
    logic [2:0]              f3;
    logic [6:0]              f7;
    logic [31:0]             imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    bundle_t                 dec;
    logic                    uses_rs1, uses_rs2;
    logic                    hazard, accept;
    logic                    valid_q;
    logic [ADDRESS_BITS-1:0] pc_q;
    bundle_t                 bundle_q;

    assign ins    = bus.instruction;
    assign opcode = opcode_e'(ins[6:0]);
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_sh = {27'b0, ins[24:20]};

    // Decode the incoming instruction into a fully defined control bundle.
    always_comb begin
        dec                  = '0;
        dec.read_sel1        = ins[19:15];
        dec.read_sel2        = ins[24:20];
        dec.rd               = ins[11:7];
        dec.funct3           = f3;
        dec.funct7           = f7;
        dec.MemSize          = `SIZE_WORD;
        dec.load_extend_sign = 1'b1;
        dec.ALU_Control      = alu(`DEFAULT);
        dec.op_A_sel         = 2'b00;
        uses_rs1             = 1'b0;
        uses_rs2             = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.wEn = 1'b1; dec.op_A_sel = 2'b11; dec.op_B_sel = 1'b1;
                dec.imm32 = imm_u; dec.ALU_Control = alu(`ADD);
            end
            OPC_AUIPC: begin
                dec.wEn = 1'b1; dec.op_A_sel = 2'b01; dec.op_B_sel = 1'b1;
                dec.imm32 = imm_u; dec.ALU_Control = alu(`ADD);
            end
            OPC_JAL: begin
                dec.wEn = 1'b1; dec.op_A_sel = 2'b10;
                dec.imm32 = imm_j; dec.ALU_Control = alu(`JAL);
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1;
                dec.wEn = 1'b1; dec.op_A_sel = 2'b10; dec.op_B_sel = 1'b1;
                dec.imm32 = imm_i; dec.ALU_Control = alu(`JALR);
                if (f3 != 3'b000) dec.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.branch_op = 1'b1; dec.imm32 = imm_b;
                case (f3)
                    3'b000:  dec.ALU_Control = alu(`BEQ);
                    3'b001:  dec.ALU_Control = alu(`BNE);
                    3'b100:  dec.ALU_Control = alu(`BLT);
                    3'b101:  dec.ALU_Control = alu(`BGE);
                    3'b110:  dec.ALU_Control = alu(`BLTU);
                    3'b111:  dec.ALU_Control = alu(`BGEU);
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                dec.wEn = 1'b1; dec.wb_sel = 1'b1; dec.op_B_sel = 1'b1;
                dec.imm32 = imm_i; dec.ALU_Control = alu(`ADD);
                case (f3)
                    3'b000:  dec.MemSize = `SIZE_BYTE;
                    3'b001:  dec.MemSize = `SIZE_HWORD;
                    3'b010:  dec.MemSize = `SIZE_WORD;
                    3'b100:  begin dec.MemSize = `SIZE_BYTE;  dec.load_extend_sign = 1'b0; end
                    3'b101:  begin dec.MemSize = `SIZE_HWORD; dec.load_extend_sign = 1'b0; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.mem_wEn = 1'b1; dec.op_B_sel = 1'b1;
                dec.imm32 = imm_s; dec.ALU_Control = alu(`ADD);
                case (f3)
                    3'b000:  dec.MemSize = `SIZE_BYTE;
                    3'b001:  dec.MemSize = `SIZE_HWORD;
                    3'b010:  dec.MemSize = `SIZE_WORD;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1 = 1'b1;
                dec.wEn = 1'b1; dec.op_B_sel = 1'b1; dec.imm32 = imm_i;
                case (f3)
                    3'b000: dec.ALU_Control = alu(`ADD);
                    3'b010: dec.ALU_Control = alu(`SLT);
                    3'b011: dec.ALU_Control = alu(`SLTU);
                    3'b100: dec.ALU_Control = alu(`XOR);
                    3'b110: dec.ALU_Control = alu(`OR);
                    3'b111: dec.ALU_Control = alu(`AND);
                    3'b001: begin
                        dec.imm32 = imm_sh; dec.ALU_Control = alu(`SLL);
                        if (f7 != 7'b0000000) dec.illegal = 1'b1;
                    end
                    default: begin
                        dec.imm32 = imm_sh;
                        if (f7 == 7'b0000000)      dec.ALU_Control = alu(`SRL);
                        else if (f7 == 7'b0100000) dec.ALU_Control = alu(`SRA);
                        else                       dec.illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                dec.wEn = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.ALU_Control = alu(`ADD);
                        3'b001:  dec.ALU_Control = alu(`SLL);
                        3'b010:  dec.ALU_Control = alu(`SLT);
                        3'b011:  dec.ALU_Control = alu(`SLTU);
                        3'b100:  dec.ALU_Control = alu(`XOR);
                        3'b101:  dec.ALU_Control = alu(`SRL);
                        3'b110:  dec.ALU_Control = alu(`OR);
                        default: dec.ALU_Control = alu(`AND);
                    endcase
                end else if (f7 == 7'b0100000) begin
                    case (f3)
                        3'b000:  dec.ALU_Control = alu(`SUB);
                        3'b101:  dec.ALU_Control = alu(`SRA);
                        default: dec.illegal = 1'b1;
                    endcase
                end
`ifdef DECODE_RV32M_EN
                else if (f7 == 7'b0000001) begin
                    case (f3)
                        3'b000:  dec.ALU_Control = alu(`MUL);
                        3'b001:  dec.ALU_Control = alu(`MULH);
                        3'b010:  dec.ALU_Control = alu(`MULHSU);
                        3'b011:  dec.ALU_Control = alu(`MULHU);
                        3'b100:  dec.ALU_Control = alu(`DIV);
                        3'b101:  dec.ALU_Control = alu(`DIVU);
                        3'b110:  dec.ALU_Control = alu(`REM);
                        default: dec.ALU_Control = alu(`REMU);
                    endcase
                end
`endif
                else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.wEn         = 1'b0;
            dec.mem_wEn     = 1'b0;
            dec.branch_op   = 1'b0;
            dec.wb_sel      = 1'b0;
            dec.ALU_Control = alu(`DEFAULT);
        end
        if (dec.rd == 5'd0) dec.wEn = 1'b0;
    end

    // Load-use hazard against the held bundle, and the input handshake.
    always_comb begin
        hazard = valid_q & bundle_q.wb_sel & bundle_q.wEn & bus.in_valid &
                 ((uses_rs1 & (dec.read_sel1 == bundle_q.rd)) |
                  (uses_rs2 & (dec.read_sel2 == bundle_q.rd)));
        bus.in_ready = bus.flush | ((~valid_q | bus.out_ready) & ~hazard);
        accept = bus.in_valid & bus.in_ready;
    end

    // One-entry pipeline register; flush outranks accept, accept outranks drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q              <= 1'b0;
            pc_q                 <= '0;
            bundle_q             <= '0;
            bundle_q.ALU_Control <= alu(`DEFAULT);
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            pc_q     <= bus.in_PC;
            bundle_q <= dec;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid        = valid_q;
    assign bus.out_PC           = pc_q;
    assign bus.read_sel1        = bundle_q.read_sel1;
    assign bus.read_sel2        = bundle_q.read_sel2;
    assign bus.rd               = bundle_q.rd;
    assign bus.funct3           = bundle_q.funct3;
    assign bus.funct7           = bundle_q.funct7;
    assign bus.imm32            = bundle_q.imm32;
    assign bus.wEn              = bundle_q.wEn;
    assign bus.mem_wEn          = bundle_q.mem_wEn;
    assign bus.branch_op        = bundle_q.branch_op;
    assign bus.op_B_sel         = bundle_q.op_B_sel;
    assign bus.wb_sel           = bundle_q.wb_sel;
    assign bus.load_extend_sign = bundle_q.load_extend_sign;
    assign bus.op_A_sel         = bundle_q.op_A_sel;
    assign bus.ALU_Control      = bundle_q.ALU_Control;
    assign bus.MemSize          = bundle_q.MemSize;
    assign bus.illegal          = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic clock = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    decode_stage_if #(.ADDRESS_BITS(32), .ALU_CTRL_BITS(6)) bus ();

    decode_stage #(.ADDRESS_BITS(32), .ALU_CTRL_BITS(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid    = v;
        bus.in_PC       = pc;
        bus.instruction = ins;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%h exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", bus.out_PC); end
        n_cmp++; if (bus.ALU_Control !== 6'h3F) begin n_err++; $display("FAIL reset_alu got=%h exp=3f", bus.ALU_Control); end
        n_cmp++; if ({bus.wEn, bus.mem_wEn, bus.imm32, bus.MemSize, bus.load_extend_sign} !== 37'h0) begin n_err++; $display("FAIL reset_fields got=%h exp=0", {bus.wEn, bus.mem_wEn, bus.imm32, bus.MemSize, bus.load_extend_sign}); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%h exp=1", bus.in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h100, 32'h00500093);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL addi_in_ready got=%h exp=1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got=%h exp=1", bus.out_valid); end
        n_cmp++; if (bus.rd !== 5'd1) begin n_err++; $display("FAIL addi_rd got=%h exp=1", bus.rd); end
        n_cmp++; if (bus.imm32 !== 32'd5) begin n_err++; $display("FAIL addi_imm got=%h exp=5", bus.imm32); end
        n_cmp++; if ({bus.wEn, bus.op_B_sel, bus.illegal} !== 3'b110) begin n_err++; $display("FAIL addi_ctl got=%b exp=110", {bus.wEn, bus.op_B_sel, bus.illegal}); end
        n_cmp++; if (bus.ALU_Control !== 6'h00) begin n_err++; $display("FAIL addi_alu got=%h exp=00", bus.ALU_Control); end
        n_cmp++; if (bus.out_PC !== 32'h100) begin n_err++; $display("FAIL addi_pc got=%h exp=100", bus.out_PC); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got=%h exp=0", bus.out_valid); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h200, 32'h0000A103);
        tick();
        n_cmp++; if ({bus.out_valid, bus.wb_sel, bus.wEn, bus.rd} !== 8'b111_00010) begin n_err++; $display("FAIL lw_bundle got=%b exp=11100010", {bus.out_valid, bus.wb_sel, bus.wEn, bus.rd}); end
        n_cmp++; if (bus.MemSize !== 2'd2) begin n_err++; $display("FAIL lw_size got=%h exp=2", bus.MemSize); end
        drive(1'b1, 32'h204, 32'h001101B3);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hazard_stall got=%h exp=0", bus.in_ready); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL hazard_bubble got=%h exp=0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL hazard_clear got=%h exp=1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if ({bus.out_valid, bus.rd, bus.wb_sel} !== 7'b1_00011_0) begin n_err++; $display("FAIL add_bundle got=%b exp=1000110", {bus.out_valid, bus.rd, bus.wb_sel}); end
        n_cmp++; if (bus.out_PC !== 32'h204) begin n_err++; $display("FAIL add_pc got=%h exp=204", bus.out_PC); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h300, 32'hFE000CE3);
        tick();
        n_cmp++; if (bus.imm32 !== 32'hFFFFFFF8) begin n_err++; $display("FAIL beq_imm got=%h exp=fffffff8", bus.imm32); end
        n_cmp++; if ({bus.branch_op, bus.wEn} !== 2'b10) begin n_err++; $display("FAIL beq_ctl got=%b exp=10", {bus.branch_op, bus.wEn}); end
        n_cmp++; if (bus.ALU_Control !== 6'h0A) begin n_err++; $display("FAIL beq_alu got=%h exp=0a", bus.ALU_Control); end
        drive(1'b1, 32'h304, 32'h4030D093);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%h exp=1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if ({bus.out_valid, bus.out_PC} !== {1'b1, 32'h304}) begin n_err++; $display("FAIL b2b_no_bubble got=%h exp=100000304", {bus.out_valid, bus.out_PC}); end
        n_cmp++; if (bus.imm32 !== 32'd3) begin n_err++; $display("FAIL srai_imm got=%h exp=3", bus.imm32); end
        n_cmp++; if (bus.ALU_Control !== 6'h07) begin n_err++; $display("FAIL srai_alu got=%h exp=07", bus.ALU_Control); end
        tick();
    endtask

    task automatic test_stall_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h400, 32'h00500093);
        tick();
        drive(1'b1, 32'h404, 32'h00700113);
        for (int unsigned i = 0; i < 3; i++) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready[%0d] got=%h exp=0", i, bus.in_ready); end
            tick();
            n_cmp++; if ({bus.out_valid, bus.out_PC, bus.imm32} !== {1'b1, 32'h400, 32'd5}) begin n_err++; $display("FAIL hold_bundle[%0d] got=%h exp=%h", i, {bus.out_valid, bus.out_PC, bus.imm32}, {1'b1, 32'h400, 32'd5}); end
        end
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%h exp=1", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%h exp=0", bus.out_valid); end
        n_cmp++; if (bus.out_PC !== 32'h400) begin n_err++; $display("FAIL flush_dropped got=%h exp=400", bus.out_PC); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stays got=%h exp=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        logic       m_illegal;
        logic       m_wen;
        logic [5:0] m_alu;
`ifdef DECODE_RV32M_EN
        m_illegal = 1'b0; m_wen = 1'b1; m_alu = 6'h18;
`else
        m_illegal = 1'b1; m_wen = 1'b0; m_alu = 6'h3F;
`endif
        drive(1'b1, 32'h500, 32'hFFFFFFFF);
        tick();
        n_cmp++; if ({bus.out_valid, bus.illegal, bus.wEn, bus.mem_wEn} !== 4'b1100) begin n_err++; $display("FAIL ones_ctl got=%b exp=1100", {bus.out_valid, bus.illegal, bus.wEn, bus.mem_wEn}); end
        n_cmp++; if (bus.ALU_Control !== 6'h3F) begin n_err++; $display("FAIL ones_alu got=%h exp=3f", bus.ALU_Control); end
        drive(1'b1, 32'h504, 32'h027302B3);
        tick();
        n_cmp++; if ({bus.illegal, bus.wEn} !== {m_illegal, m_wen}) begin n_err++; $display("FAIL mul_ctl got=%b exp=%b", {bus.illegal, bus.wEn}, {m_illegal, m_wen}); end
        n_cmp++; if (bus.ALU_Control !== m_alu) begin n_err++; $display("FAIL mul_alu got=%h exp=%h", bus.ALU_Control, m_alu); end
        drive(1'b1, 32'h508, 32'h0020B023);
        tick();
        n_cmp++; if ({bus.illegal, bus.mem_wEn} !== 2'b10) begin n_err++; $display("FAIL sd_ctl got=%b exp=10", {bus.illegal, bus.mem_wEn}); end
        drive(1'b1, 32'h50C, 32'h00100013);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if ({bus.illegal, bus.wEn, bus.imm32} !== {2'b00, 32'd1}) begin n_err++; $display("FAIL rd0_ctl got=%h exp=1", {bus.illegal, bus.wEn, bus.imm32}); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h0000A103);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_hold_pre got=%h exp=1", bus.out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got=%h exp=0", bus.out_valid); end
        n_cmp++; if ({bus.ALU_Control, bus.out_PC} !== {6'h3F, 32'h0}) begin n_err++; $display("FAIL rst_async_bundle got=%h exp=%h", {bus.ALU_Control, bus.out_PC}, {6'h3F, 32'h0}); end
        @(negedge clock);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_back_to_back();
        test_stall_flush();
        test_illegal();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked RV32I decode stage between fetch and execute.
- Decodes one instruction per cycle into a full control bundle, with valid/ready flow control in and out.
- Detects load-use hazards and inserts a bubble; supports flush on redirect.
- Flags illegal encodings; every control field is fully defined for every opcode, with no held values.

Parameters:
ADDRESS_BITS, 32, PC width
ALU_CTRL_BITS, 6, ALU_Control width (`ADD ... `DEFAULT codes)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts this cycle
in_PC  in  ADDRESS_BITS  PC of instruction
instruction  in  32  raw instruction
flush  in  1  redirect: kill held and incoming instruction
out_valid  out  1  bundle valid
out_ready  in  1  execute consumes bundle
out_PC  out  ADDRESS_BITS  registered PC
read_sel1, read_sel2, rd  out  5 each  register addresses
funct3 / funct7  out  3 / 7  passthrough fields
imm32  out  32  extended immediate
wEn, mem_wEn, branch_op, op_B_sel, wb_sel, load_extend_sign  out  1 each  controls (same encoding as existing decode)
op_A_sel  out  2  00 rs1, 01 PC, 10 PC+4, 11 zero
ALU_Control  out  ALU_CTRL_BITS  ALU operation
MemSize  out  2  `SIZE_BYTE/`SIZE_HWORD/`SIZE_WORD
illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0 and out_PC=0.
  - All bundle fields are 0, except ALU_Control=`DEFAULT.
  - in_ready follows its combinational equation.
- Combinational decode:
  - Immediate types: I, S, B, U, J; shift-immediate uses zero-extended shamt.
  - Default field values, applied before the opcode case: wEn=0, mem_wEn=0, branch_op=0, op_A_sel=00, op_B_sel=0, wb_sel=0, MemSize=`SIZE_WORD, load_extend_sign=1, ALU_Control=`DEFAULT, illegal=0.
- wEn is forced 0 when rd==0.
- Illegal encodings:
  - Cases: unknown opcode; load funct3 in {011,110,111}; store funct3>010; branch funct3 in {010,011}; R-type or shift-imm funct7 not 0000000/0100000 where applicable.
  - Result: illegal=1, all enables 0, ALU_Control=`DEFAULT.
- Pipeline register (1 entry):
  - in_ready = (~out_valid | out_ready) & ~hazard.
  - On in_valid & in_ready, the bundle loads next edge and out_valid=1.
  - Else, if out_ready, out_valid<=0.
  - Latency is 1 cycle.
  - Bundle holds stable while out_valid & ~out_ready.
- Hazard (load-use):
  - Condition: out_valid & held wb_sel & held wEn & in_valid & incoming instruction reads held rd.
  - rs1 counts as read for all but LUI/AUIPC/JAL; rs2 counts only for R/S/B.
  - While hazard: in_ready=0. If out_ready, the register drains to a bubble (out_valid=0); hazard clears next cycle and the instruction is accepted.
- Flush (synchronous, highest priority):
  - Next edge out_valid=0.
  - in_ready=1 that cycle; any incoming instruction is discarded.
- Simultaneous consume and accept: the new bundle replaces the old with no bubble.
- Reset mid-stall: the register is cleared immediately.

Optional Feature:
- Macro DECODE_RV32M_EN.
- Defined: R-type funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU via ALU_Control codes `MUL..`REMU; wEn=1, illegal=0.
- Undefined: funct7=0000001 is illegal.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle out_valid=1, rd=1, imm32=5, wEn=1, op_B_sel=1, ALU_Control=`ADD.
- 0x0000A103 (lw x2,0(x1)) followed by 0x001101B3 (add x3,x2,x1) → in_ready=0 one cycle; bubble (out_valid=0) between the load and the add; add decoded with rd=3.
- 0xFE000CE3 (beq x0,x0,-8) → imm32=0xFFFFFFF8, branch_op=1, ALU_Control=`BEQ, wEn=0. 0x4030D093 (srai) → imm32=3, ALU_Control=`SRA.
- Hold out_ready=0 for 3 cycles with out_valid=1 → bundle and out_PC unchanged, in_ready=0; assert flush → out_valid=0 next edge; incoming instruction dropped.
- 0xFFFFFFFF → illegal=1, wEn=0, mem_wEn=0. 0x027302B3 (mul) → illegal=0 with DECODE_RV32M_EN, illegal=1 without.
- reset_n low mid-hold → out_valid=0 asynchronously, ALU_Control=`DEFAULT.
